// File: rtl/pmem_arb_pkg.sv
// Shared types and constants for the physical-memory arbiter.
// State encoding and arbitration-mode selectors used by pmem_arbiter and arb_pick.
package pmem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Index reached by stepping 'off' places past 'base' on a ring of n clients.
  function automatic int ring_index(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select for the memory arbiter.
// Fixed priority is a round-robin search that always starts just past client N-1.
module arb_pick
  import pmem_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int PRIO_MODE   = PRIO_RR,
  localparam int IDX_W      = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] pending,
  input  logic [IDX_W-1:0]       last_grant,
  output logic [IDX_W-1:0]       winner,
  output logic                   any_valid
);

  int   base;
  int   cand;
  logic found;

  assign base      = (PRIO_MODE == PRIO_FIXED) ? (NUM_CLIENTS - 1) : int'(last_grant);
  assign any_valid = |pending;

  // NOTE: every variable written in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int off = 1; off <= NUM_CLIENTS; off++) begin
      cand = ring_index(base, off, NUM_CLIENTS);
      if (!found && pending[cand]) begin
        found  = 1'b1;
        winner = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// N-client arbiter in front of a single physical-memory port.
// Grants one client per transaction, latches its command, and routes pmem_resp back to it.
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 256,
  parameter int PRIO_MODE   = PRIO_RR
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_CLIENTS-1:0]                c_read,
  input  logic [NUM_CLIENTS-1:0]                c_write,
  input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]    c_addr,
  input  logic [NUM_CLIENTS-1:0][LINE_W-1:0]    c_wdata,
  output logic [NUM_CLIENTS-1:0]                c_resp,
  output logic [LINE_W-1:0]                     c_rdata,
  input  logic                                  pmem_resp,
  input  logic [LINE_W-1:0]                     pmem_rdata,
  output logic                                  pmem_read,
  output logic                                  pmem_write,
  output logic [ADDR_W-1:0]                     pmem_address,
  output logic [LINE_W-1:0]                     pmem_wdata,
  output logic [$clog2(NUM_CLIENTS)-1:0]        grant_idx,
  output logic                                  busy
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic             op_write_q, op_write_d;

  logic [NUM_CLIENTS-1:0] pending;
  logic [IDX_W-1:0]       winner;
  logic                   any_valid;

  assign pending = c_read | c_write;

  arb_pick #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .PRIO_MODE   (PRIO_MODE)
  ) u_pick (
    .pending    (pending),
    .last_grant (last_grant_q),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  // State register.
  // NOTE: clocked blocks use non-blocking (<=) so every flop samples pre-edge values;
  // blocking assignments here would make results depend on evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. A response in BUSY always returns to IDLE, which forces the
  // one-cycle bubble that keeps a client from seeing a stale c_resp.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (any_valid) state_d = ARB_BUSY;
      ARB_BUSY: if (pmem_resp) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Grant bookkeeping. A simultaneous read+write from one client latches the write;
  // the read stays pending and competes again after the bubble.
  always_comb begin
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    op_write_d   = op_write_q;
    if (state_q == ARB_IDLE && any_valid) begin
      grant_idx_d = winner;
      op_write_d  = c_write[winner];
    end
    if (state_q == ARB_BUSY && pmem_resp) begin
      last_grant_d = grant_idx_q;
    end
  end

  // The pointer resets to N-1 so client 0 wins the first round-robin contest.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_idx_q  <= '0;
      last_grant_q <= IDX_W'(NUM_CLIENTS - 1);
      op_write_q   <= 1'b0;
    end else begin
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      op_write_q   <= op_write_d;
    end
  end

  // Outputs. Address and data are forwarded live from the granted client, which
  // holds them stable until its response.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    c_resp       = '0;
    if (state_q == ARB_BUSY) begin
      pmem_read           = ~op_write_q;
      pmem_write          = op_write_q;
      pmem_address        = c_addr[grant_idx_q];
      pmem_wdata          = c_wdata[grant_idx_q];
      c_resp[grant_idx_q] = pmem_resp;
    end
  end

  assign c_rdata   = pmem_rdata;
  assign grant_idx = grant_idx_q;
  assign busy      = (state_q == ARB_BUSY);

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Parametrised N-client arbiter between cache-line clients (instruction cache, data cache, prefetcher, …) and a single physical-memory port. It grants one client at a time, using round-robin or fixed priority, and latches the granted command for the whole transaction. The granted client's address and data are forwarded to memory, and `pmem_resp` is routed back to that client only. It sits between the L1 caches and physical memory (or L2), and replaces the fixed two-client i-cache/d-cache arbiter.

## Interface
Parameters:
- `NUM_CLIENTS`, 2: number of requesters, ≥2.
- `ADDR_W`, 32: address width.
- `LINE_W`, 256: cache-line width.
- `PRIO_MODE`, 0: 0 = round-robin, 1 = fixed priority (client 0 highest).

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `c_read`  in  NUM_CLIENTS: per-client read request.
- `c_write`  in  NUM_CLIENTS: per-client write request.
- `c_addr`  in  NUM_CLIENTS×ADDR_W: per-client line address.
- `c_wdata`  in  NUM_CLIENTS×LINE_W: per-client write line.
- `c_resp`  out  NUM_CLIENTS: per-client completion, one-hot or zero.
- `c_rdata`  out  LINE_W: read line, broadcast to all clients.
- `pmem_resp`  in  1: memory completion.
- `pmem_rdata`  in  LINE_W: memory read line.
- `pmem_read`  out  1: memory read command.
- `pmem_write`  out  1: memory write command.
- `pmem_address`  out  ADDR_W: memory address.
- `pmem_wdata`  out  LINE_W: memory write line.
- `grant_idx`  out  $clog2(NUM_CLIENTS): index of the current or last granted client.
- `busy`  out  1: high while in state BUSY.

## Operation
- States: IDLE, BUSY.
- IDLE:
  - A client is pending if `c_read|c_write` is set.
  - If any client is pending, the picker selects a winner. On the next edge: `grant_idx` ← winner; `op_write` ← `c_write[winner]`, else read; state → BUSY.
- Picker rules:
  - Round-robin: search starts at `last_grant+1` modulo NUM_CLIENTS, and the first pending client wins.
  - Fixed priority: the lowest pending index wins.
- BUSY:
  - `pmem_read` = !op_write; `pmem_write` = op_write.
  - `pmem_address` = `c_addr[grant_idx]` and `pmem_wdata` = `c_wdata[grant_idx]`, forwarded live. Clients must hold address and data stable until their `c_resp`.
  - `c_resp[grant_idx]` = `pmem_resp`; all other bits are 0.
  - On `pmem_resp`: `last_grant` ← `grant_idx`; state → IDLE.
- `c_rdata` = `pmem_rdata` at all times.
- In IDLE, `pmem_read`, `pmem_write`, `pmem_address` and `pmem_wdata` are all 0, and `c_resp` is 0.
- If one client asserts read and write together, the write is serviced first. The read stays pending and is re-arbitrated normally.
- The command is latched. If a client drops its request while in BUSY, the transaction still completes and the response is still delivered to that client.
- `pmem_resp` in IDLE is ignored and produces no `c_resp`.

## Timing
- Reset values:
  - state IDLE.
  - `grant_idx` 0.
  - `last_grant` NUM_CLIENTS−1, so client 0 wins the first round-robin contest.
  - `busy` 0, `pmem_read` 0, `pmem_write` 0, `c_resp` 0, `pmem_address` 0, `pmem_wdata` 0.
- Request to command latency: a request is sampled in IDLE at cycle t, and `pmem_read`/`pmem_write` is high from cycle t+1.
- Response path:
  - `c_resp` follows `pmem_resp` combinationally, in the same cycle.
  - The command is deasserted at cycle k+1, where k is the `pmem_resp` cycle.
  - The earliest next grant has its command at k+2. This is one mandatory IDLE bubble, which prevents a client from seeing a stale response.
- Round-robin fairness: with all clients continuously requesting, grants cycle 0,1,…,N−1,0. Any pending client is served within NUM_CLIENTS transactions.
- Reset mid-BUSY:
  - Next cycle is IDLE with commands dropped and the pointer reset.
  - A late `pmem_resp` is ignored.
  - Memory must tolerate the aborted command.
- A request that arrives in the same cycle as `pmem_resp` is not granted until the IDLE cycle.

## Structure
- Package `pmem_arb_pkg`: state enum `arb_state_t {ARB_IDLE, ARB_BUSY}`, plus constants `PRIO_RR=0` and `PRIO_FIXED=1`.
- Sub-module `arb_pick`: combinational winner select, parametrised by NUM_CLIENTS and mode.
  - Inputs: pending vector, `last_grant`.
  - Outputs: winner index, `any_valid`.
- Top module: state register, `grant_idx`, `last_grant`, `op_write` registers, and the output muxes.

## Test plan
- N=2, round-robin; `c_read[1]` only, addr 0x0000_1000, `pmem_resp` after 5 cycles → `pmem_address`=0x1000 and `pmem_read`=1 from t+1; `c_resp`=2'b10 for one cycle; `c_rdata`=`pmem_rdata`.
- N=2, round-robin; both clients read continuously, 4 transactions → grant order 0,1,0,1; `c_resp` never has 2 bits set; one IDLE cycle between transactions.
- N=4, fixed priority; clients 1 and 3 pending, client 0 requests mid-transaction → order 1, 0, 3; client 3 is starved while 0 and 1 keep requesting.
- Client 0 asserts read and write with addr 0xA0 → first a write (`pmem_wdata`=`c_wdata[0]`), then after the IDLE bubble a read at 0xA0.
- `rst` asserted in BUSY with `pmem_resp` arriving the next cycle → `pmem_read`=0, `busy`=0, no `c_resp`; next contest is won by client 0.
- `pmem_resp` pulsed while IDLE → `c_resp` stays 0; state unchanged.
